// File: rtl/pa_strobed_out_ctrl_if.sv
// Port A write-path bus/handshake bundle for pa_strobed_out_ctrl.
//   master (CPU bus + peripheral side, e.g. testbench): drives cs_n, wr_n, a,
//          din, mode1_en, inte_a, ack_n; observes pa_data, pa_out_ld, obf_n, intr.
//   slave  (controller): the reverse.
interface pa_strobed_out_ctrl_if;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] a;
  logic [7:0] din;
  logic       mode1_en;
  logic       inte_a;
  logic       ack_n;
  logic [7:0] pa_data;
  logic       pa_out_ld;
  logic       obf_n;
  logic       intr;

  modport master (
    output cs_n, wr_n, a, din, mode1_en, inte_a, ack_n,
    input  pa_data, pa_out_ld, obf_n, intr
  );

  modport slave (
    input  cs_n, wr_n, a, din, mode1_en, inte_a, ack_n,
    output pa_data, pa_out_ld, obf_n, intr
  );
endinterface

// File: rtl/pa_strobed_out_ctrl.sv
// 8255A Port A write path and Mode 1 strobed-output handshake.
// Converts asynchronous CPU writes into a one-clock active-low pa_out_ld pulse
// with stable pa_data for the Port A output latch, and in Mode 1 runs the
// OBF#/ACK#/INTR handshake with the peripheral.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - slave side of pa_strobed_out_ctrl_if:
//           in : cs_n, wr_n, a[1:0], din[7:0], mode1_en, inte_a, ack_n
//           out: pa_data[7:0], pa_out_ld, obf_n, intr
module pa_strobed_out_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  pa_strobed_out_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FULL   = 2'd1,
    ACKING = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_wr_n_s1, r_wr_n_s2, r_wr_n_s3;
  logic       r_ack_n_s1, r_ack_n_s2, r_ack_n_s3;
  logic       r_cap_cs_n;
  logic [1:0] r_cap_a;
  logic [7:0] r_cap_d;
  logic [7:0] r_pa_data;
  logic       r_pa_out_ld;
  logic       r_obf_n;
  logic       r_intr;

  logic       w_write;
  logic       w_ack_fall;
  logic       w_ack_rise;

  // Two-flop synchronisers plus a third copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_n_s1  <= 1'b1;
      r_wr_n_s2  <= 1'b1;
      r_wr_n_s3  <= 1'b1;
      r_ack_n_s1 <= 1'b1;
      r_ack_n_s2 <= 1'b1;
      r_ack_n_s3 <= 1'b1;
    end else begin
      r_wr_n_s1  <= bus.wr_n;
      r_wr_n_s2  <= r_wr_n_s1;
      r_wr_n_s3  <= r_wr_n_s2;
      r_ack_n_s1 <= bus.ack_n;
      r_ack_n_s2 <= r_ack_n_s1;
      r_ack_n_s3 <= r_ack_n_s2;
    end
  end

  // Bus fields are sampled while the synchronised strobe is still low, so the
  // values used at the rising edge are the last ones seen during the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_cs_n <= 1'b1;
      r_cap_a    <= '0;
      r_cap_d    <= '0;
    end else if (!r_wr_n_s2) begin
      r_cap_cs_n <= bus.cs_n;
      r_cap_a    <= bus.a;
      r_cap_d    <= bus.din;
    end
  end

  assign w_write    = !r_wr_n_s3 && r_wr_n_s2 && !r_cap_cs_n && (r_cap_a == 2'b00);
  assign w_ack_fall =  r_ack_n_s3 && !r_ack_n_s2;
  assign w_ack_rise = !r_ack_n_s3 &&  r_ack_n_s2;

  // Latch load path, active in both modes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pa_data   <= '0;
      r_pa_out_ld <= 1'b1;
    end else begin
      r_pa_out_ld <= !w_write;
      if (w_write) begin
        r_pa_data <= r_cap_d;
      end
    end
  end

  // Mode 1 handshake; a write always wins over a same-cycle ACK edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_obf_n <= 1'b1;
      r_intr  <= 1'b0;
    end else if (!bus.mode1_en) begin
      r_state <= IDLE;
      r_obf_n <= 1'b1;
      r_intr  <= 1'b0;
    end else begin
      if (!bus.inte_a) begin
        r_intr <= 1'b0;
      end
      if (w_write) begin
        r_state <= FULL;
        r_obf_n <= 1'b0;
        r_intr  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_obf_n <= 1'b1;
          end
          FULL: begin
            if (w_ack_fall) begin
              r_state <= ACKING;
              r_obf_n <= 1'b1;
            end
          end
          ACKING: begin
            if (w_ack_rise) begin
              r_state <= IDLE;
              r_intr  <= bus.inte_a;
            end
          end
          default: begin
            r_state <= IDLE;
            r_obf_n <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.pa_data   = r_pa_data;
  assign bus.pa_out_ld = r_pa_out_ld;
  assign bus.obf_n     = r_obf_n;
  assign bus.intr      = r_intr;

endmodule

// File: tb/tb_pa_strobed_out_ctrl.sv
module tb_pa_strobed_out_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pa_strobed_out_ctrl_if bus_if ();

  pa_strobed_out_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // ---------------- reference model ----------------
  // Inputs as seen at each of the last four rising edges (index 0 = newest).
  typedef struct packed {
    logic       wr;
    logic       ack;
    logic       cs;
    logic [1:0] a;
    logic [7:0] d;
  } smp_t;

  smp_t       hist [4];
  logic [7:0] m_data;
  logic       m_ld;
  logic       m_full;   // peripheral has not yet taken the data
  logic       m_acked;  // peripheral pulled ACK low, waiting for release
  logic       m_intr;

  always @(posedge clk or negedge reset) begin
    logic w, fall, rise;
    if (!reset) begin
      m_data  = 8'h00;
      m_ld    = 1'b1;
      m_full  = 1'b0;
      m_acked = 1'b0;
      m_intr  = 1'b0;
      for (int i = 0; i < 4; i++)
        hist[i] = '{wr: 1'b1, ack: 1'b1, cs: 1'b1, a: 2'b00, d: 8'h00};
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = '{wr: bus_if.wr_n, ack: bus_if.ack_n, cs: bus_if.cs_n,
                  a: bus_if.a, d: bus_if.din};
      // Strobe edges take effect two edges after they are first sampled;
      // the bus fields used are those present one edge before that.
      w    = hist[2].wr && !hist[3].wr && !hist[1].cs && (hist[1].a == 2'b00);
      fall = hist[3].ack && !hist[2].ack;
      rise = !hist[3].ack && hist[2].ack;
      m_ld = !w;
      if (w) m_data = hist[1].d;
      if (!bus_if.mode1_en) begin
        m_full = 1'b0; m_acked = 1'b0; m_intr = 1'b0;
      end else begin
        if (w) begin
          m_full = 1'b1; m_acked = 1'b0; m_intr = 1'b0;
        end else if (m_full && fall) begin
          m_full = 1'b0; m_acked = 1'b1;
        end else if (m_acked && rise) begin
          m_acked = 1'b0; m_intr = bus_if.inte_a;
        end
        if (!bus_if.inte_a) m_intr = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, sampled on the falling edge
  always @(negedge clk) begin
    chk("pa_data",   bus_if.pa_data,          m_data);
    chk("pa_out_ld", {7'd0, bus_if.pa_out_ld}, {7'd0, m_ld});
    chk("obf_n",     {7'd0, bus_if.obf_n},     {7'd0, !m_full});
    chk("intr",      {7'd0, bus_if.intr},      {7'd0, m_intr});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // wr_n rises just before edge k; results sampled after edges k+2 and k+3.
  task automatic wr_op(input logic [1:0] aa, input logic [7:0] dd, input logic cs,
                       input logic ack_too,
                       output logic ld2, output logic ld3, output logic [7:0] d2,
                       output logic obf2, output logic intr2);
    @(negedge clk);
    bus_if.cs_n = cs; bus_if.a = aa; bus_if.din = dd; bus_if.wr_n = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.wr_n = 1'b1;
    if (ack_too) bus_if.ack_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ld2 = bus_if.pa_out_ld; d2 = bus_if.pa_data; obf2 = bus_if.obf_n; intr2 = bus_if.intr;
    @(posedge clk);
    #1;
    ld3 = bus_if.pa_out_ld;
    @(negedge clk);
    bus_if.cs_n = 1'b1; bus_if.din = 8'($urandom); bus_if.a = 2'($urandom);
    if (ack_too) bus_if.ack_n = 1'b1;
  endtask

  task automatic ack_op(input int low, input int high);
    @(negedge clk);
    bus_if.ack_n = 1'b0;
    cyc(low);
    bus_if.ack_n = 1'b1;
    cyc(high);
  endtask

  task automatic mode0_a5_write;
    logic l2, l3, o2, i2;
    logic [7:0] d2;
    wr_op(2'b00, 8'hA5, 1'b0, 1'b0, l2, l3, d2, o2, i2);
    chk("m0 ld low at k+2", {7'd0, l2}, 8'h00);
    chk("m0 ld high at k+3", {7'd0, l3}, 8'h01);
    chk("m0 data A5", d2, 8'hA5);
    chk("m0 obf_n", {7'd0, o2}, 8'h01);
    chk("m0 intr", {7'd0, i2}, 8'h00);
  endtask

  initial begin
    logic l2, l3, o2, i2;
    logic [7:0] d2;
    bus_if.cs_n = 1'b1; bus_if.wr_n = 1'b1; bus_if.a = 2'b00; bus_if.din = 8'h00;
    bus_if.mode1_en = 1'b0; bus_if.inte_a = 1'b0; bus_if.ack_n = 1'b1;

    // Reset and Mode 0 write
    cyc(3);
    chk("reset pa_data", bus_if.pa_data, 8'h00);
    chk("reset ld", {7'd0, bus_if.pa_out_ld}, 8'h01);
    chk("reset obf_n", {7'd0, bus_if.obf_n}, 8'h01);
    chk("reset intr", {7'd0, bus_if.intr}, 8'h00);
    reset = 1'b1;
    cyc(2);
    mode0_a5_write();

    // Ignored writes
    wr_op(2'b01, 8'h77, 1'b0, 1'b0, l2, l3, d2, o2, i2);
    chk("a01 no ld", {7'd0, l2}, 8'h01);
    chk("a01 data kept", d2, 8'hA5);
    wr_op(2'b00, 8'h88, 1'b1, 1'b0, l2, l3, d2, o2, i2);
    chk("cs1 no ld", {7'd0, l2}, 8'h01);
    chk("cs1 data kept", d2, 8'hA5);

    // Mode 1, interrupts enabled
    bus_if.mode1_en = 1'b1; bus_if.inte_a = 1'b1;
    cyc(2);
    wr_op(2'b00, 8'h3C, 1'b0, 1'b0, l2, l3, d2, o2, i2);
    chk("m1 obf low", {7'd0, o2}, 8'h00);
    chk("m1 data 3C", d2, 8'h3C);
    @(negedge clk); bus_if.ack_n = 1'b0;
    cyc(4);
    chk("m1 ack obf high", {7'd0, bus_if.obf_n}, 8'h01);
    chk("m1 ack intr still 0", {7'd0, bus_if.intr}, 8'h00);
    bus_if.ack_n = 1'b1;
    cyc(4);
    chk("m1 intr set", {7'd0, bus_if.intr}, 8'h01);
    wr_op(2'b00, 8'h11, 1'b0, 1'b0, l2, l3, d2, o2, i2);
    chk("m1 intr cleared", {7'd0, i2}, 8'h00);
    chk("m1 obf low again", {7'd0, o2}, 8'h00);
    chk("m1 data 11", d2, 8'h11);

    // Mode 1, interrupts disabled
    bus_if.inte_a = 1'b0;
    ack_op(4, 4);
    chk("inte0 intr", {7'd0, bus_if.intr}, 8'h00);
    wr_op(2'b00, 8'h22, 1'b0, 1'b0, l2, l3, d2, o2, i2);
    ack_op(4, 4);
    chk("inte0 full hs intr", {7'd0, bus_if.intr}, 8'h00);
    chk("inte0 full hs obf", {7'd0, bus_if.obf_n}, 8'h01);
    bus_if.inte_a = 1'b1;
    cyc(3);
    chk("inte late intr", {7'd0, bus_if.intr}, 8'h00);

    // Write and ACK falling edge in the same cycle while FULL
    wr_op(2'b00, 8'h44, 1'b0, 1'b0, l2, l3, d2, o2, i2);
    wr_op(2'b00, 8'h55, 1'b0, 1'b1, l2, l3, d2, o2, i2);
    chk("w+ack obf", {7'd0, o2}, 8'h00);
    chk("w+ack data", d2, 8'h55);
    chk("w+ack ld", {7'd0, l2}, 8'h00);
    cyc(4);
    chk("w+ack stays full", {7'd0, bus_if.obf_n}, 8'h00);
    chk("w+ack no intr", {7'd0, bus_if.intr}, 8'h00);

    // Async reset in the middle of an acknowledge
    wr_op(2'b00, 8'h66, 1'b0, 1'b0, l2, l3, d2, o2, i2);
    @(negedge clk); bus_if.ack_n = 1'b0;
    cyc(4);
    chk("pre-reset acking obf", {7'd0, bus_if.obf_n}, 8'h01);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async rst data", bus_if.pa_data, 8'h00);
    chk("async rst ld", {7'd0, bus_if.pa_out_ld}, 8'h01);
    chk("async rst obf", {7'd0, bus_if.obf_n}, 8'h01);
    chk("async rst intr", {7'd0, bus_if.intr}, 8'h00);
    @(negedge clk);
    bus_if.ack_n = 1'b1; bus_if.mode1_en = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    mode0_a5_write();

    // Randomised traffic, checked by the per-cycle compare
    bus_if.mode1_en = 1'b1;
    for (int it = 0; it < 250; it++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        wr_op(($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00, 8'($urandom),
              ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
              l2, l3, d2, o2, i2);
      end else if (r <= 7) begin
        ack_op($urandom_range(2, 5), $urandom_range(2, 5));
      end else if (r == 8) begin
        @(negedge clk); bus_if.mode1_en = ($urandom_range(0, 9) < 7);
      end else begin
        @(negedge clk); bus_if.inte_a = ($urandom_range(0, 9) < 7);
      end
      cyc($urandom_range(0, 2));
    end
    cyc(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pa_strobed_out_ctrl.md
# pa_strobed_out_ctrl

Port A write-path and Mode 1 strobed-output handshake controller for the 8255A. Sits directly upstream of the Port A output latch. It turns asynchronous CPU bus writes into a one-clock active-low `pa_out_ld` pulse with stable `pa_data`, which drive the latch's `PAOutLd`/`Din`. In Mode 1 it also runs the OBF#/ACK#/INTR handshake with the peripheral.

## Interface
- No parameters; widths fixed (8-bit data, 2-bit address).
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `cs_n` input 1: chip select from bus, active low, asynchronous.
- `wr_n` input 1: write strobe from bus, active low, asynchronous.
- `a` input 2: register address; `2'b00` selects Port A.
- `din` input 8: CPU data bus, stable while `wr_n` low.
- `mode1_en` input 1: 1 = group A Mode 1 (strobed), 0 = Mode 0 (basic).
- `inte_a` input 1: Port A interrupt enable (PC6 bit-set/reset flag).
- `ack_n` input 1: peripheral acknowledge, active low, asynchronous.
- `pa_data` output 8: data to the Port A latch `Din`.
- `pa_out_ld` output 1: active-low load to the Port A latch; low for exactly one clk per write.
- `obf_n` output 1: output buffer full, active low (PC7).
- `intr` output 1: interrupt request A, active high (PC3).

## Operation
- Synchronisers: `wr_n` and `ack_n` each pass through 2 flops (`*_s1`, `*_s2`), reset to 1. Edge detection uses `*_s2` and a third registered copy `*_s3`.
- Capture: while `wr_n_s2`=0, register `cs_n`, `a` and `din` every clk into `cap_cs_n`, `cap_a` and `cap_d`. Reset values: 1, 0, 0.
- Write event W: `wr_n_s2` rising (s3=0, s2=1), `cap_cs_n`=0 and `cap_a`=00. Writes to other addresses or with CS inactive are ignored entirely.
- On W, in both modes: `pa_data`<=`cap_d`; `pa_out_ld`<=0 for one clk, then 1. `pa_data` holds until the next W.
- Handshake FSM, active only when `mode1_en`=1:
  - IDLE: `obf_n`=1. W -> FULL (`obf_n`<=0, `intr`<=0).
  - FULL: `obf_n`=0. `ack_n_s2` falling -> ACKING (`obf_n`<=1). W -> FULL (data reloaded, `intr`<=0).
  - ACKING: `obf_n`=1. `ack_n_s2` rising -> IDLE, and `intr`<=`inte_a`. W -> FULL.
- `intr` stays set until the next W, a `mode1_en` drop, `inte_a`=0, or reset. `inte_a`=0 forces `intr`=0 combinationally-registered next clk.
- Mode 0 (`mode1_en`=0): FSM held in IDLE, `obf_n`=1, `intr`=0, `ack_n` ignored. W still loads data.
- `mode1_en` 1->0 mid-handshake: next clk FSM->IDLE, `obf_n`<=1, `intr`<=0.
- Simultaneous W and ACK falling edge in the same clk: W wins, state FULL, `obf_n`=0.
- ACK edges in IDLE are ignored. An ACK rising edge without a prior falling edge in FULL is ignored.

## Timing
- Reset (`reset`=0, any time, async): `pa_data`=8'h00, `pa_out_ld`=1, `obf_n`=1, `intr`=0, FSM=IDLE, sync flops=1, capture regs cleared. A write in progress at reset is lost.
- Write latency: `wr_n` rises before edge k -> `wr_n_s2`=1 after edge k+1 -> W decoded in the cycle after k+1.
  - At edge k+2: `pa_data` updated, `pa_out_ld`=0, `obf_n`=0 (Mode 1).
  - At edge k+3: `pa_out_ld`=1.
- `pa_data` changes only at the same edge `pa_out_ld` falls, so it is stable for the whole low period.
- ACK latency: `ack_n` fall before edge k -> `obf_n`=1 after edge k+2. `ack_n` rise before edge j -> `intr`=1 after edge j+2.
- Minimum `wr_n` and `ack_n` low width: 2 clk. Shorter pulses may be missed.

## Test plan
- Reset then Mode 0 write of 8'hA5 to a=00: `pa_out_ld` low exactly 1 clk at k+2, `pa_data`=A5; `obf_n`=1 and `intr`=0 throughout.
- Write with a=01, then a write with `cs_n`=1: no `pa_out_ld` pulse, `pa_data` unchanged.
- Mode 1, `inte_a`=1: write 8'h3C -> `obf_n`=0. `ack_n` low 4 clk -> `obf_n`=1. `ack_n` high -> `intr`=1. Next write 8'h11 -> `intr`=0, `obf_n`=0, `pa_data`=11.
- Mode 1, `inte_a`=0: full handshake completes with `intr` staying 0. Then set `inte_a`=1 after ACK: `intr` stays 0.
- W and `ack_n` falling edge aligned to the same clk in FULL: state FULL, `obf_n`=0, `pa_data` = new value.
- Assert `reset` low mid-ACKING, async between edges: all outputs at reset values immediately; the first write after release behaves as in the Mode 0 write scenario.
